sr_excitation_sequencer: RTL and testbench

Drive side of the SR flip-flop interface. It accepts a stream of target state bits and buffers them in a small FIFO. For each bit it computes the minimal S/R excitation from a shadow copy of q, holds that excitation for one clock, then checks the flip-flop's q/qb feedback. It never issues the forbidden 11 excitation. Mismatches and illegal complements are counted and flagged.

---
 rtl/sr_seq_pkg.sv | 26 ++
 rtl/sr_seq_fifo.sv | 61 ++++++
 rtl/sr_excitation_sequencer.sv | 159 +++++++++++++++
 tb/tb_sr_excitation_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_seq_pkg.sv
// Shared types and the S/R excitation rule used by the excitation sequencer.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Excitation encoding is {s, r}; 2'b11 is deliberately absent.
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_RST  = 2'b01;
  localparam logic [1:0] EXC_SET  = 2'b10;

  function automatic logic [1:0] excite(input logic tgt, input logic shadow);
    if (tgt == shadow) begin
      return EXC_HOLD;
    end else if (tgt) begin
      return EXC_SET;
    end else begin
      return EXC_RST;
    end
  endfunction

endpackage

// File: rtl/sr_seq_fifo.sv
// 1-bit wide synchronous FIFO with wrap-bit pointers; head is read combinationally
// so the consumer can pop and use the value at the same edge.
module sr_seq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        mem_q [DEPTH];
  logic        mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sr_excitation_sequencer.sv
// Drives S/R excitations for a queued stream of target bits and verifies the
// flip-flop's q/qb feedback one cycle after each excitation.
module sr_excitation_sequencer
  import sr_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  input  logic             qb_fb,
  input  logic             err_clr,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic             shadow_q, shadow_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic fifo_push;
  logic fifo_pop;
  logic fifo_dout;
  logic fifo_full;
  logic fifo_empty;
  logic check_pass;

  assign in_ready  = !fifo_full && (state_q != HALT);
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign s         = s_q;
  assign r         = r_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  sr_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (in_bit),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    shadow_d   = shadow_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    fifo_pop   = 1'b0;
    check_pass = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tgt_d      = fifo_dout;
          {s_d, r_d} = excite(fifo_dout, shadow_q);
          state_d    = DRIVE;
        end
      end

      DRIVE: begin
        state_d = CHECK;
      end

      CHECK: begin
        // An unknown feedback value falls through to the fail branch.
        if ((q_fb == tgt_q) && (qb_fb == ~q_fb)) begin
          check_pass = 1'b1;
        end else begin
          check_pass = 1'b0;
        end

        if (check_pass) begin
          shadow_d = tgt_q;
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
          end
          if (q_fb == 1'b1) begin
            shadow_d = 1'b1;
          end else begin
            shadow_d = 1'b0;
          end
        end

        if (!check_pass && STOP_ON_ERR) begin
          state_d = HALT;
        end else if (!fifo_empty) begin
          // Back-to-back: the next excitation is based on the just-resolved shadow.
          fifo_pop   = 1'b1;
          tgt_d      = fifo_dout;
          {s_d, r_d} = excite(fifo_dout, shadow_d);
          state_d    = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end

      HALT: begin
        if (err_clr) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= 1'b0;
      shadow_q  <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      shadow_q  <= shadow_d;
      s_q       <= s_d;
      r_q       <= r_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_sr_excitation_sequencer.sv
// Directed bench: two sequencers (continue-on-error and stop-on-error) each
// driving a behavioural SR flip-flop with injectable feedback faults.
module tb_sr_excitation_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       err_clr;
  logic [1:0] mode;  // 0 = healthy, 1 = q stuck at 0, 2 = qb equals q

  logic       in_ready0, s0, r0, busy0, err0;
  logic [7:0] err_cnt0;
  logic       in_ready1, s1, r1, busy1, err1;
  logic [7:0] err_cnt1;
  logic       ff0_q, ff1_q;
  logic       q_fb0, qb_fb0, q_fb1, qb_fb1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_excitation_sequencer #(.DEPTH(4), .CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready0),
    .s(s0), .r(r0), .q_fb(q_fb0), .qb_fb(qb_fb0), .err_clr(err_clr),
    .busy(busy0), .err(err0), .err_cnt(err_cnt0)
  );

  sr_excitation_sequencer #(.DEPTH(4), .CNT_W(8), .STOP_ON_ERR(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready1),
    .s(s1), .r(r1), .q_fb(q_fb1), .qb_fb(qb_fb1), .err_clr(err_clr),
    .busy(busy1), .err(err1), .err_cnt(err_cnt1)
  );

  // Behavioural SR flip-flops sharing the sequencer reset.
  always @(posedge clk) begin
    if (rst) ff0_q <= 1'b0;
    else if (s0 && !r0) ff0_q <= 1'b1;
    else if (r0 && !s0) ff0_q <= 1'b0;
  end

  always @(posedge clk) begin
    if (rst) ff1_q <= 1'b0;
    else if (s1 && !r1) ff1_q <= 1'b1;
    else if (r1 && !s1) ff1_q <= 1'b0;
  end

  assign q_fb0  = (mode == 2'd1) ? 1'b0 : ff0_q;
  assign qb_fb0 = (mode == 2'd2) ? q_fb0 : ~q_fb0;
  assign q_fb1  = (mode == 2'd1) ? 1'b0 : ff1_q;
  assign qb_fb1 = (mode == 2'd2) ? q_fb1 : ~q_fb1;

  typedef struct {
    logic       vld;
    logic       b;
    logic [1:0] sr;
    logic       busy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and the
  // forbidden 11 excitation is checked on both instances every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("s_and_r_dut0", {31'd0, s0 & r0}, 32'd0);
    chk("s_and_r_dut1", {31'd0, s1 & r1}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy0}, 32'd0);
  endtask

  task automatic push_bit(input logic b);
    int n = 0;
    in_bit   = b;
    in_valid = 1'b1;
    while (!in_ready0 && n < 60) begin
      tick();
      n++;
    end
    chk("push_ready_timeout", {31'd0, in_ready0}, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("push bit=%0b err_cnt0=%0d", b, err_cnt0);
  endtask

  task automatic push_stream(input int n, input logic first_bit);
    int   acc = 0;
    int   cyc = 0;
    logic b   = first_bit;
    in_valid = 1'b1;
    while (acc < n && cyc < 4 * n + 20) begin
      in_bit = b;
      if (in_ready0) begin
        acc++;
        b = ~b;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_accepted", acc, n);
    $display("stream of %0d bits, err_cnt0=%0d", acc, err_cnt0);
  endtask

  initial begin
    logic [7:0] bits;
    logic [3:0] idx;
    int         npulse;
    logic       acc_now;
    logic [1:0] exp_sr;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    err_clr  = 1'b0;
    mode     = 2'd0;

    // ---------------- reset state
    do_reset();
    chk("rst_s", {31'd0, s0}, 32'd0);
    chk("rst_r", {31'd0, r0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);

    // ---------------- push 1,0,0,1 with a healthy flip-flop
    vecs[0] = '{vld: 1'b1, b: 1'b1, sr: 2'b00, busy: 1'b1};
    vecs[1] = '{vld: 1'b1, b: 1'b0, sr: 2'b10, busy: 1'b1};
    vecs[2] = '{vld: 1'b1, b: 1'b0, sr: 2'b00, busy: 1'b1};
    vecs[3] = '{vld: 1'b1, b: 1'b1, sr: 2'b01, busy: 1'b1};
    vecs[4] = '{vld: 1'b0, b: 1'b0, sr: 2'b00, busy: 1'b1};
    vecs[5] = '{vld: 1'b0, b: 1'b0, sr: 2'b00, busy: 1'b1};
    vecs[6] = '{vld: 1'b0, b: 1'b0, sr: 2'b00, busy: 1'b1};
    vecs[7] = '{vld: 1'b0, b: 1'b0, sr: 2'b10, busy: 1'b1};
    vecs[8] = '{vld: 1'b0, b: 1'b0, sr: 2'b00, busy: 1'b1};
    vecs[9] = '{vld: 1'b0, b: 1'b0, sr: 2'b00, busy: 1'b0};
    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].vld;
      in_bit   = vecs[i].b;
      tick();
      $display("vec %0d: in_valid=%0b in_bit=%0b -> s=%0b r=%0b busy=%0b",
               i, vecs[i].vld, vecs[i].b, s0, r0, busy0);
      chk("vec_sr", {30'd0, s0, r0}, {30'd0, vecs[i].sr});
      chk("vec_busy", {31'd0, busy0}, {31'd0, vecs[i].busy});
    end
    in_valid = 1'b0;
    chk("vec_err", {31'd0, err0}, 32'd0);
    chk("vec_err_cnt", {24'd0, err_cnt0}, 32'd0);

    // ---------------- back-to-back pushes fill the FIFO
    do_reset();
    bits   = 8'b0101_0101;  // presented LSB first: 1,0,1,0,...
    idx    = 4'd0;
    npulse = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      in_valid = (idx < 4'd8);
      in_bit   = (idx < 4'd8) ? bits[idx[2:0]] : 1'b0;
      acc_now  = in_valid && in_ready0;
      tick();
      if (acc_now) idx = idx + 4'd1;
      if (cyc == 7) chk("full_in_ready", {31'd0, in_ready0}, 32'd0);
      if (cyc == 8) chk("after_pop_in_ready", {31'd0, in_ready0}, 32'd1);
      if (s0 || r0) begin
        exp_sr = (npulse % 2 == 0) ? 2'b10 : 2'b01;
        if (npulse < 8) chk("fill_pulse", {30'd0, s0, r0}, {30'd0, exp_sr});
        npulse++;
      end
    end
    in_valid = 1'b0;
    chk("fill_accepted", {28'd0, idx}, 32'd8);
    chk("fill_pulse_count", npulse, 8);
    chk("fill_err", {31'd0, err0}, 32'd0);
    $display("fill: accepted=%0d pulses=%0d", idx, npulse);

    // ---------------- q stuck at 0: continue vs halt
    do_reset();
    mode = 2'd1;
    push_bit(1'b1);
    wait_idle0();
    chk("stuck_err", {31'd0, err0}, 32'd1);
    chk("stuck_err_cnt", {24'd0, err_cnt0}, 32'd1);
    chk("halt_in_ready", {31'd0, in_ready1}, 32'd0);
    chk("halt_sr", {30'd0, s1, r1}, 32'd0);
    chk("halt_busy", {31'd0, busy1}, 32'd1);
    chk("halt_err_cnt", {24'd0, err_cnt1}, 32'd1);
    mode = 2'd0;
    in_bit   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!(s0 || r0) && n < 10) begin
        tick();
        n++;
      end
    end
    chk("resync_redrive", {30'd0, s0, r0}, 32'h2);
    chk("halt_still_sr", {30'd0, s1, r1}, 32'd0);
    wait_idle0();
    chk("resync_err_cnt", {24'd0, err_cnt0}, 32'd1);
    chk("resync_err_sticky", {31'd0, err0}, 32'd1);
    chk("halt_ignores_push", {31'd0, in_ready1}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("err_clr: err0=%0b err1=%0b busy1=%0b", err0, err1, busy1);
    chk("clr_err0", {31'd0, err0}, 32'd0);
    chk("clr_err_cnt0", {24'd0, err_cnt0}, 32'd1);
    chk("clr_err1", {31'd0, err1}, 32'd0);
    chk("clr_err_cnt1", {24'd0, err_cnt1}, 32'd1);
    chk("clr_in_ready1", {31'd0, in_ready1}, 32'd1);
    chk("clr_busy1", {31'd0, busy1}, 32'd0);

    // ---------------- qb equals q, then saturation
    mode = 2'd2;
    push_bit(1'b0);
    wait_idle0();
    chk("qbq_err", {31'd0, err0}, 32'd1);
    chk("qbq_err_cnt", {24'd0, err_cnt0}, 32'd2);
    push_stream(253, 1'b1);
    wait_idle0();
    chk("sat_reach", {24'd0, err_cnt0}, 32'd255);
    push_stream(47, 1'b1);
    wait_idle0();
    chk("sat_hold", {24'd0, err_cnt0}, 32'd255);

    // ---------------- reset during DRIVE with 3 bits queued
    mode = 2'd0;
    do_reset();
    bits = 8'b0001_0101;  // 1,0,1,0,1,0
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_drive", {30'd0, s0, r0}, 32'h2);
    chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    tick();
    $display("mid-drive reset: s=%0b r=%0b busy=%0b", s0, r0, busy0);
    chk("mid_rst_sr", {30'd0, s0, r0}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("mid_rst_err_cnt", {24'd0, err_cnt0}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_empty", {31'd0, busy0}, 32'd0);
    chk("post_rst_sr", {30'd0, s0, r0}, 32'd0);

    // ---------------- randomized stimulus, s&r checked every cycle in tick()
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      err_clr  = ($urandom_range(0, 7) == 0);
      mode     = 2'($urandom_range(0, 2));
      tick();
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;
    mode     = 2'd0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
